// File: rtl/oled_spi_rx.sv
// Receive end of the OLED 4-wire serial link.
// Oversamples SCLK/CS/DC/DIN with CLK and rebuilds each 8-bit transfer (MSB first)
// as a 9-bit {dc, byte} word. Words are queued in a small FIFO with a valid/ready
// read port, plus a sticky overflow flag, a framing-error pulse and a word counter.
module oled_spi_rx #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        OLED_SCLK,
  input  logic        OLED_CS,
  input  logic        OLED_DC,
  input  logic        OLED_DIN,
  output logic [8:0]  RX_DATA,
  output logic        RX_VALID,
  input  logic        RX_READY,
  output logic        OVERFLOW,
  output logic        FRAME_ERR,
  output logic [15:0] BYTE_CNT
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;

  // Bit positions inside the synchroniser vectors.
  localparam int unsigned IdxSclk = 0;
  localparam int unsigned IdxCs   = 1;
  localparam int unsigned IdxDc   = 2;
  localparam int unsigned IdxDin  = 3;

  // ---------------------------------------------------------------------------
  // Input conditioning
  // ---------------------------------------------------------------------------
  logic [3:0] sync1_q;
  logic [3:0] sync2_q;
  logic       sclk_hist_q;
  logic       cs_hist_q;

  logic       sclk_s;
  logic       cs_s;
  logic       dc_s;
  logic       din_s;
  logic       sclk_rise;
  logic       cs_rise;

  // Two-flop synchronisers for all link inputs, plus one history flop for SCLK and CS.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      sclk_hist_q <= 1'b0;
      cs_hist_q   <= 1'b0;
    end else begin
      sync1_q     <= {OLED_DIN, OLED_DC, OLED_CS, OLED_SCLK};
      sync2_q     <= sync1_q;
      sclk_hist_q <= sync2_q[IdxSclk];
      cs_hist_q   <= sync2_q[IdxCs];
    end
  end

  assign sclk_s    = sync2_q[IdxSclk];
  assign cs_s      = sync2_q[IdxCs];
  assign dc_s      = sync2_q[IdxDc];
  assign din_s     = sync2_q[IdxDin];
  assign sclk_rise = sclk_s & ~sclk_hist_q;
  assign cs_rise   = cs_s & ~cs_hist_q;

  // ---------------------------------------------------------------------------
  // Bit engine
  // ---------------------------------------------------------------------------
  logic [2:0] bitn_q;
  logic [6:0] sh_q;
  logic       frame_err_q;
  logic       wr_req;
  logic [8:0] wr_word;

  // Shift in one bit per SCLK rise while selected; deselect parks the engine at bit 0.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      bitn_q      <= 3'd0;
      sh_q        <= 7'd0;
      frame_err_q <= 1'b0;
    end else begin
      // bitn_q still holds the pre-deselect count on the cs_rise cycle.
      frame_err_q <= cs_rise && (bitn_q != 3'd0);
      if (cs_s) begin
        bitn_q <= 3'd0;
        sh_q   <= 7'd0;
      end else if (sclk_rise) begin
        bitn_q <= bitn_q + 3'd1;
        sh_q   <= {sh_q[5:0], din_s};
      end
    end
  end

  // The 8th rise completes the byte; DC is taken at that same edge.
  assign wr_req    = sclk_rise & ~cs_s & (bitn_q == 3'd7);
  assign wr_word   = {dc_s, sh_q, din_s};
  assign FRAME_ERR = frame_err_q;

  // ---------------------------------------------------------------------------
  // Receive FIFO
  // ---------------------------------------------------------------------------
  logic [8:0]      mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q;
  logic [PtrW-1:0] rd_ptr_q;
  logic [CntW-1:0] cnt_q;
  logic            overflow_q;
  logic [15:0]     byte_cnt_q;

  logic            full;
  logic            rd_en;
  logic            wr_en;
  logic            drop;

  assign full     = (cnt_q == CntW'(FIFO_DEPTH));
  assign RX_VALID = (cnt_q != '0);
  assign rd_en    = RX_VALID & RX_READY;
  // A write into a full FIFO still fits when the head leaves in the same cycle.
  assign wr_en    = wr_req & (~full | rd_en);
  assign drop     = wr_req & full & ~rd_en;

  // Word storage; cleared on reset so the idle head reads as zero.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        mem_q[i] <= 9'd0;
      end
    end else if (wr_en) begin
      mem_q[wr_ptr_q] <= wr_word;
    end
  end

  // Pointers and occupancy; pointers wrap naturally since the depth is a power of two.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (rd_en) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      unique case ({wr_en, rd_en})
        2'b10:   cnt_q <= cnt_q + CntW'(1);
        2'b01:   cnt_q <= cnt_q - CntW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Sticky overflow and accepted-word counter.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      overflow_q <= 1'b0;
      byte_cnt_q <= 16'd0;
    end else begin
      if (drop) begin
        overflow_q <= 1'b1;
      end
      if (wr_en) begin
        byte_cnt_q <= byte_cnt_q + 16'd1;
      end
    end
  end

  assign RX_DATA  = mem_q[rd_ptr_q];
  assign OVERFLOW = overflow_q;
  assign BYTE_CNT = byte_cnt_q;

endmodule

// File: doc/oled_spi_rx.md
# oled_spi_rx

Receive-side model of the OLED 4-wire serial link: samples OLED_SCLK, OLED_CS, OLED_DC and OLED_DIN with the system clock and deserialises each 8-bit transfer, MSB first, into a 9-bit {dc, byte} word. Completed words are buffered in a small FIFO and handed out on a valid/ready port. It is the panel-side counterpart of the SPI transmitter. It is used as the bench/display-emulator end of the link, and as a loopback checker for the init sequence.

## Interface
- FIFO_DEPTH, 4, number of buffered words; power of two, ≥2
- CLK  in  1  system clock; must be ≥4× OLED_SCLK frequency
- RST_N  in  1  reset, asynchronous and active-low
- OLED_SCLK  in  1  serial clock, idle low; DIN/DC sampled on rising edge
- OLED_CS  in  1  chip select, active low
- OLED_DC  in  1  0 = command byte, 1 = data byte
- OLED_DIN  in  1  serial data, MSB first
- RX_DATA  out  9  {dc, byte} at FIFO head; dc in bit 8
- RX_VALID  out  1  FIFO not empty
- RX_READY  in  1  consumer accepts head word when RX_VALID & RX_READY
- OVERFLOW  out  1  sticky: a word was dropped because the FIFO was full
- FRAME_ERR  out  1  one-cycle pulse: CS deasserted with a partial byte
- BYTE_CNT  out  16  count of words written to the FIFO; wraps 0xFFFF→0

## Operation
- Input conditioning:
  - SCLK, CS, DC and DIN each pass through a 2-flop synchroniser.
  - SCLK and CS each get one further history flop for edge detection.
  - sclk_rise = sync2 & ~hist.
  - cs_rise = sync2 & ~hist, on the CS signal.
- Bit engine:
  - State is a 3-bit bit counter `bitn` and a 7-bit shift register `sh`.
  - While synced CS is low, each sclk_rise shifts synced DIN into `sh` and increments `bitn`.
  - When sclk_rise occurs with bitn = 7, the word {DC_sync, sh[6:0], DIN_sync} is written to the FIFO. DC is the value at that 8th edge. `bitn` then wraps to 0.
  - While synced CS is high, sclk_rise is ignored and `bitn` and `sh` are held at 0.
  - On cs_rise with bitn ≠ 0: partial bits are discarded, FRAME_ERR pulses high for 1 cycle, and nothing is written.
- FIFO:
  - Circular buffer with read/write pointers and an occupancy count of width log2(FIFO_DEPTH)+1.
  - Read occurs when RX_VALID & RX_READY.
  - Write while not full: accepted.
  - Write while full with a read in the same cycle: accepted; occupancy unchanged.
  - Write while full with no read: word dropped, OVERFLOW set, BYTE_CNT not incremented.
  - Read while empty: no effect.
- OVERFLOW clears only on reset.
- BYTE_CNT increments once per accepted write.
- Reset, including mid-byte or mid-FIFO:
  - Clears synchronisers, history flops, `bitn`, `sh`, FIFO pointers and occupancy, and BYTE_CNT.
  - The first sclk_rise after reset release is bit 7 of a new byte, provided CS is low.

## Timing
- Reset values: RX_DATA = 0, RX_VALID = 0, OVERFLOW = 0, FRAME_ERR = 0, BYTE_CNT = 0.
- Synchronisers and history flops reset to 0. An SCLK that is already high at reset release produces one sclk_rise after sync.
- Edge detection latency: with SCLK first sampled high at CLK edge k, sclk_rise is asserted in the cycle following edge k+1.
- Write latency:
  - The FIFO write occurs at edge k+2.
  - If the FIFO was empty, RX_VALID is high and RX_DATA is valid after edge k+2.
  - Total: 3 CLK edges from the first sampling of the 8th SCLK high.
- RX_DATA is read combinationally from FIFO storage at the read pointer. It is stable while RX_VALID is high and no read occurs.
- A read at edge m advances the head. RX_VALID drops after m if the FIFO became empty.
- FRAME_ERR asserts 3 CLK edges after CS is first sampled high, and lasts exactly 1 cycle.
- SCLK high and low phases must each be ≥2 CLK periods. DIN and DC must be stable across the sampled SCLK rise, plus 2 CLK periods.

## Test plan
- Reset hold, then release with all inputs low → every output 0; no spurious writes in 100 cycles.
- CS low, send 0xAE with DC=0, then 0xA5 with DC=1, SCLK = CLK/8, RX_READY=1:
  - Receive 0x0AE then 0x1A5, each with a one-cycle RX_VALID.
  - BYTE_CNT = 2.
- RX_READY=0, send 5 bytes 0x01..0x05 (FIFO_DEPTH=4):
  - OVERFLOW = 1, BYTE_CNT = 4.
  - Draining yields 0x01..0x04 only.
- RX_READY=0, fill to 4 words, then raise RX_READY in the exact cycle of the 5th byte's write:
  - No overflow; occupancy stays 4.
  - Draining yields all 5 bytes in order.
- Send 5 bits, then raise CS:
  - FRAME_ERR pulses for 1 cycle; no write.
  - A following full byte 0x3C is received intact as 0x03C.
- Assert RST_N low after 4 bits of a byte with 2 words queued:
  - RX_VALID = 0, BYTE_CNT = 0.
  - After release, a full byte 0x81 with DC=1 → 0x181.
